cpu_stream_loader: RTL

- Upstream feeder for the pipelined CPU top.
- Accepts a valid/ready 32-bit command/data stream and turns it into instruction-memory and data-memory write cycles on the CPU's external ports (addr_ext/wen_ext/wdata_ext and addr_ext_2/wen_ext_2/wdata_ext_2).
- Drives the CPU's `enable` once a run command is received.
- Replaces hand-driven testbench preload; sits between a host link and the CPU.

---
 rtl/cpu_loader_pkg.sv | 22 ++
 rtl/loader_wr_port.sv | 32 +++
 rtl/cpu_stream_loader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cpu_loader_pkg.sv
// Shared encodings for the CPU stream loader: header opcodes, header field positions, FSM states.
package cpu_loader_pkg;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 30;

  typedef enum logic [1:0] {
    OP_LOAD_IMEM = 2'b00,
    OP_LOAD_DMEM = 2'b01,
    OP_RUN       = 2'b10,
    OP_HALT      = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/loader_wr_port.sv
// Registered addr/wen/wdata triple driving one CPU external memory write port.
// Latency: strobe to wen is 1 cycle. Backpressure: none, accepts a strobe every cycle.
// A strobe in the reset cycle is dropped; addr/wdata hold their last value between pulses.
module loader_wr_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_stb,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] addr,
  output logic              wen,
  output logic [DATA_W-1:0] wdata
);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      wen   <= 1'b0;
      wdata <= '0;
    end else begin
      wen <= wr_stb;
      if (wr_stb) begin
        addr  <= wr_addr;
        wdata <= wr_data;
      end
    end
  end

endmodule

// File: rtl/cpu_stream_loader.sv
// Turns a valid/ready command stream into CPU imem/dmem preload writes and drives cpu_enable.
// Latency: data transfer to wen is 1 cycle, 1 word/cycle. Backpressure: s_ready depends on
// state only; low solely in the error state, which is left only through reset.
module cpu_stream_loader
  import cpu_loader_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_wen,
  output logic [DATA_W-1:0] imem_wdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_wen,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              cpu_enable,
  output logic              busy,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  state_e            state;
  state_e            state_nxt;
  logic              tgt_dmem;
  logic [CNT_W-1:0]  remain;
  logic [ADDR_W-1:0] cur_addr;
  logic              imem_stb;
  logic              dmem_stb;
  logic              xfer;
  op_e               hdr_op;
  logic [CNT_W-1:0]  hdr_cnt;
  logic              hdr_is_load;

  assign xfer        = s_valid && s_ready;
  assign hdr_op      = op_e'(s_data[OP_MSB:OP_LSB]);
  assign hdr_cnt     = s_data[CNT_W-1:0];
  assign hdr_is_load = (hdr_op == OP_LOAD_IMEM) || (hdr_op == OP_LOAD_DMEM);

  // Status outputs are decoded from the registered state, so cpu_enable
  // follows a RUN/HALT handshake by exactly one cycle.
  assign s_ready    = (state != ST_ERR);
  assign busy       = (state == ST_ADDR) || (state == ST_DATA);
  assign error      = (state == ST_ERR);
  assign cpu_enable = (state == ST_RUN);

  always_comb begin
    state_nxt = state;
    imem_stb  = 1'b0;
    dmem_stb  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          case (hdr_op)
            OP_LOAD_IMEM,
            OP_LOAD_DMEM: if (hdr_cnt != '0) state_nxt = ST_ADDR;
            OP_RUN:       state_nxt = ST_RUN;
            OP_HALT:      state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_ADDR: begin
        if (xfer) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (xfer) begin
          dmem_stb = tgt_dmem;
          imem_stb = !tgt_dmem;
          if (remain == CNT_W'(1)) state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (xfer) state_nxt = (hdr_op == OP_HALT) ? ST_IDLE : ST_ERR;
      end
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tgt_dmem <= 1'b0;
      remain   <= '0;
      cur_addr <= '0;
      checksum <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        case (state)
          ST_IDLE: begin
            // A zero-count load still opens (and closes) a section, so it clears the checksum.
            if (hdr_is_load) begin
              tgt_dmem <= (hdr_op == OP_LOAD_DMEM);
              remain   <= hdr_cnt;
              checksum <= '0;
            end
          end
          ST_ADDR: cur_addr <= s_data[ADDR_W-1:0];
          ST_DATA: begin
            cur_addr <= cur_addr + ADDR_W'(ADDR_STEP);
            remain   <= remain - CNT_W'(1);
            checksum <= checksum ^ s_data;
          end
          default: ;
        endcase
      end
    end
  end

  loader_wr_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_imem_port (
    .clk     (clk),
    .rst     (rst),
    .wr_stb  (imem_stb),
    .wr_addr (cur_addr),
    .wr_data (s_data),
    .addr    (imem_addr),
    .wen     (imem_wen),
    .wdata   (imem_wdata)
  );

  loader_wr_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dmem_port (
    .clk     (clk),
    .rst     (rst),
    .wr_stb  (dmem_stb),
    .wr_addr (cur_addr),
    .wr_data (s_data),
    .addr    (dmem_addr),
    .wen     (dmem_wen),
    .wdata   (dmem_wdata)
  );

endmodule
